// File: rtl/imm_gen_pipe_pkg.sv
// Shared immediate-format encodings and widths for the immediate generator.
// The same immSrc encodings are driven by the control unit, so the datapath
// never compares against literal codes.
package imm_gen_pipe_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SRC_W   = 3;

  // immSrc encodings; 3'b101..3'b111 are illegal.
  typedef enum logic [SRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  // Pipeline occupancy: output register only, or output register plus skid entry.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_state_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational instruction -> immediate decoder.
// Builds a 32-bit sign-extended immediate, then sign-extends it to XLEN.
// Optional feature macro: IMM_PC_ADJ_EN (subtract PC_ADJ from B/J results).
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_ADJ = 4
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [SRC_W-1:0]   immSrc,
  output logic [XLEN-1:0]    immExt,
  output logic               illegal
);

  logic [31:0]     w_imm32;
  logic            w_pc_rel;
  logic [XLEN-1:0] w_ext;
  logic            w_unused_opcode;

  // Opcode bits carry no immediate information.
  assign w_unused_opcode = ^instr[6:0];

  // Field extraction per format, sign bit instr[31] replicated to 32 bits.
  always_comb begin
    w_imm32  = '0;
    w_pc_rel = 1'b0;
    illegal  = 1'b0;
    case (immSrc)
      IMM_I: w_imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: begin
        w_imm32  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        w_pc_rel = 1'b1;
      end
      IMM_J: begin
        w_imm32  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        w_pc_rel = 1'b1;
      end
      IMM_U: w_imm32 = {instr[31:12], 12'b0};
      default: illegal = 1'b1;
    endcase
  end

  assign w_ext = XLEN'(signed'(w_imm32));

`ifdef IMM_PC_ADJ_EN
  // Branch/jump offsets are relative to a PC that has already advanced.
  assign immExt = w_pc_rel ? (w_ext - XLEN'(PC_ADJ)) : w_ext;
`else
  logic w_unused_pc_rel;
  assign w_unused_pc_rel = w_pc_rel;
  assign immExt          = w_ext;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with valid/ready handshake.
// Output register plus one skid entry; in_ready is a flop output.
// Counts accepted illegal immSrc encodings with a saturating counter.
// Optional feature macro: IMM_PC_ADJ_EN (handled inside imm_decode).
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PC_ADJ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [SRC_W-1:0]   immSrc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    immExt,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  occ_state_e r_state, w_state_nxt;

  logic [XLEN-1:0]  w_dec_imm;
  logic             w_dec_ill;
  logic             w_in_fire;
  logic             w_load_out;
  logic             w_out_from_skid;
  logic             w_load_skid;

  logic             r_in_ready;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_ill;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;
  logic [CNT_W-1:0] r_cnt;

  imm_decode #(
    .XLEN   (XLEN),
    .PC_ADJ (PC_ADJ)
  ) u_decode (
    .instr   (instr),
    .immSrc  (immSrc),
    .immExt  (w_dec_imm),
    .illegal (w_dec_ill)
  );

  assign w_in_fire   = in_valid && r_in_ready;
  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != OCC_EMPTY);
  assign immExt      = r_out_imm;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_ill;
  assign illegal_cnt = r_cnt;

  // Occupancy state register; in_ready is registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != OCC_TWO);
    end
  end

  // Next occupancy and data-movement strobes.
  // In OCC_TWO in_ready is low, so a drain only promotes the skid entry.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_in_fire) begin
          w_load_out  = 1'b1;
          w_state_nxt = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (out_ready) begin
          if (w_in_fire) w_load_out  = 1'b1;
          else           w_state_nxt = OCC_EMPTY;
        end else if (w_in_fire) begin
          w_load_skid = 1'b1;
          w_state_nxt = OCC_TWO;
        end
      end
      OCC_TWO: begin
        if (out_ready) begin
          w_load_out      = 1'b1;
          w_out_from_skid = 1'b1;
          w_state_nxt     = OCC_ONE;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
  end

  // Output register and skid entry payloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_imm  <= '0;
      r_out_tag  <= '0;
      r_out_ill  <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_load_out) begin
        if (w_out_from_skid) begin
          r_out_imm <= r_skid_imm;
          r_out_tag <= r_skid_tag;
          r_out_ill <= r_skid_ill;
        end else begin
          r_out_imm <= w_dec_imm;
          r_out_tag <= in_tag;
          r_out_ill <= w_dec_ill;
        end
      end
      if (w_load_skid) begin
        r_skid_imm <= w_dec_imm;
        r_skid_tag <= in_tag;
        r_skid_ill <= w_dec_ill;
      end
    end
  end

  // Saturating count of accepted illegal items.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_in_fire && w_dec_ill && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors, backpressure,
// randomized traffic against a queue-based reference model, counter
// saturation and mid-operation reset. A 64-bit instance shares the inputs.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [2:0]  immSrc;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] immExt;
  logic [3:0]  out_tag;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;

  logic        in_ready_64;
  logic        out_valid_64;
  logic [63:0] immExt_64;
  logic [3:0]  out_tag_64;
  logic        out_illegal_64;
  logic [7:0]  illegal_cnt_64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4), .CNT_W(8), .PC_ADJ(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .immSrc(immSrc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .immExt(immExt),
    .out_tag(out_tag), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4), .CNT_W(8), .PC_ADJ(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
    .instr(instr), .immSrc(immSrc), .in_tag(in_tag),
    .out_valid(out_valid_64), .out_ready(out_ready), .immExt(immExt_64),
    .out_tag(out_tag_64), .out_illegal(out_illegal_64), .illegal_cnt(illegal_cnt_64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [3:0]  tag;
    logic        ill;
  } item_t;

  item_t q[$];
  int    mcnt;

  // Per-tick observations filled by tick()
  logic        acc, popped, underflow, stall_prev, r_stalled;
  item_t       exp_item;
  logic        got_valid, got_ill;
  logic [31:0] got_imm32;
  logic [63:0] got_imm64;
  logic [3:0]  got_tag;
  logic [7:0]  got_cnt;
  int          exp_cnt;
  logic [31:0] prev_imm32;
  logic [3:0]  prev_tag;
  logic        prev_ill;

  // Reference: arithmetic reconstruction of each immediate format.
  function automatic item_t model_item(logic [31:0] ins, logic [2:0] src, logic [3:0] tag);
    item_t  it;
    longint s;
    longint v;
    s = $signed(ins);
    it.ill = 1'b0;
    case (src)
      3'd0: v = s >>> 20;
      3'd1: v = (s >>> 25) * 32 + longint'(ins[11:7]);
      3'd2: v = (s >>> 31) * 4096 + longint'(ins[7]) * 2048
                + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      3'd3: v = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      3'd4: v = (s >>> 12) * 4096;
      default: begin v = 0; it.ill = 1'b1; end
    endcase
`ifdef IMM_PC_ADJ_EN
    if (src == 3'd2 || src == 3'd3) v = v - 4;
`endif
    it.imm = v;
    it.tag = tag;
    return it;
  endfunction

  // Advance one cycle: sample outputs at negedge, update model, step clock.
  task automatic tick();
    popped     = 1'b0;
    acc        = 1'b0;
    underflow  = 1'b0;
    stall_prev = r_stalled;
    prev_imm32 = got_imm32;
    prev_tag   = got_tag;
    prev_ill   = got_ill;
    got_valid  = out_valid;
    got_imm32  = immExt;
    got_imm64  = immExt_64;
    got_tag    = out_tag;
    got_ill    = out_illegal;
    got_cnt    = illegal_cnt;
    exp_cnt    = mcnt;
    if (rst) begin
      q.delete();
      mcnt      = 0;
      r_stalled = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() > 0) begin
          exp_item = q.pop_front();
          popped   = 1'b1;
        end else begin
          underflow = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        q.push_back(model_item(instr, immSrc, in_tag));
        if (immSrc > 3'd4 && mcnt < 255) mcnt++;
      end
      r_stalled = out_valid && !out_ready;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; immSrc = '0; in_tag = '0;
    q.delete(); mcnt = 0; r_stalled = 1'b0;
    got_imm32 = '0; got_tag = '0; got_ill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (immExt !== 32'h0) begin n_fail++; $display("FAIL reset_immExt got=%h exp=0", immExt); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal got=%b exp=0", out_illegal); end
    n_checks++; if (illegal_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", illegal_cnt); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] v_ins [6];
    logic [2:0]  v_src [6];
    logic [31:0] v_e32 [6];
    logic [63:0] v_e64 [6];
    v_ins[0] = 32'hFFF00093; v_src[0] = 3'd0; v_e32[0] = 32'hFFFFFFFF; v_e64[0] = 64'hFFFFFFFFFFFFFFFF;
    v_ins[1] = 32'hFE112E23; v_src[1] = 3'd1; v_e32[1] = 32'hFFFFFFFC; v_e64[1] = 64'hFFFFFFFFFFFFFFFC;
    v_ins[2] = 32'h123450B7; v_src[2] = 3'd4; v_e32[2] = 32'h12345000; v_e64[2] = 64'h0000000012345000;
    v_ins[3] = 32'h800000B7; v_src[3] = 3'd4; v_e32[3] = 32'h80000000; v_e64[3] = 64'hFFFFFFFF80000000;
`ifdef IMM_PC_ADJ_EN
    v_ins[4] = 32'hFE000CE3; v_src[4] = 3'd2; v_e32[4] = 32'hFFFFFFF4; v_e64[4] = 64'hFFFFFFFFFFFFFFF4;
`else
    v_ins[4] = 32'hFE000CE3; v_src[4] = 3'd2; v_e32[4] = 32'hFFFFFFF8; v_e64[4] = 64'hFFFFFFFFFFFFFFF8;
`endif
    v_ins[5] = 32'h7FF00093; v_src[5] = 3'd0; v_e32[5] = 32'h000007FF; v_e64[5] = 64'h00000000000007FF;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; instr = v_ins[i]; immSrc = v_src[i]; in_tag = 4'(i + 1);
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_out_valid got=%b exp=1", i, out_valid); end
      n_checks++; if (immExt !== v_e32[i]) begin n_fail++; $display("FAIL dir%0d_imm32 got=%h exp=%h", i, immExt, v_e32[i]); end
      n_checks++; if (immExt_64 !== v_e64[i]) begin n_fail++; $display("FAIL dir%0d_imm64 got=%h exp=%h", i, immExt_64, v_e64[i]); end
      n_checks++; if (out_tag !== 4'(i + 1)) begin n_fail++; $display("FAIL dir%0d_tag got=%h exp=%h", i, out_tag, 4'(i + 1)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s_imm;
    int          n_pop;
    out_ready = 1'b0;
    in_valid = 1'b1; immSrc = 3'd0; instr = $urandom; in_tag = 4'd1;
    tick();
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_accept1 got=%b exp=1", acc); end
    s_imm = immExt;
    instr = $urandom; immSrc = 3'd1; in_tag = 4'd2;
    tick();
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_accept2 got=%b exp=1", acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (out_tag !== 4'd1 || immExt !== s_imm) begin n_fail++; $display("FAIL bp_stable1 got=%h/%h exp=1/%h", out_tag, immExt, s_imm); end
    instr = $urandom; immSrc = 3'd3; in_tag = 4'd3;
    tick();
    n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_holdoff3 got=%b exp=0", acc); end
    n_checks++; if (out_tag !== 4'd1 || immExt !== s_imm) begin n_fail++; $display("FAIL bp_stable2 got=%h/%h exp=1/%h", out_tag, immExt, s_imm); end
    out_ready = 1'b1;
    n_pop = 0;
    for (int k = 0; k < 10 && n_pop < 3; k++) begin
      tick();
      if (acc) in_valid = 1'b0;
      if (popped) begin
        n_checks++;
        if (got_tag !== 4'(n_pop + 1) || got_imm32 !== exp_item.imm[31:0]) begin
          n_fail++; $display("FAIL bp_order%0d got=%h/%h exp=%h/%h", n_pop, got_tag, got_imm32, 4'(n_pop + 1), exp_item.imm[31:0]);
        end
        n_pop++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (n_pop != 3) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=3", n_pop); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      immSrc    = 3'($urandom_range(0, 7));
      instr     = $urandom;
      in_tag    = 4'($urandom);
      if (c >= 590) begin in_valid = 1'b0; out_ready = 1'b1; end
      tick();
      if (popped) begin
        n_checks++;
        if ({got_imm32, got_imm64, got_tag, got_ill} !== {exp_item.imm[31:0], exp_item.imm, exp_item.tag, exp_item.ill}) begin
          n_fail++; $display("FAIL rnd_item got=%h/%h/%h/%b exp=%h/%h/%h/%b", got_imm32, got_imm64, got_tag, got_ill,
                             exp_item.imm[31:0], exp_item.imm, exp_item.tag, exp_item.ill);
        end
      end
      if (underflow) begin n_checks++; n_fail++; $display("FAIL rnd_spurious_output got=out_valid exp=empty"); end
      if (stall_prev && got_valid) begin
        n_checks++;
        if ({got_imm32, got_tag, got_ill} !== {prev_imm32, prev_tag, prev_ill}) begin
          n_fail++; $display("FAIL rnd_stall_stable got=%h/%h/%b exp=%h/%h/%b", got_imm32, got_tag, got_ill, prev_imm32, prev_tag, prev_ill);
        end
      end else if (stall_prev) begin
        n_checks++; n_fail++; $display("FAIL rnd_stall_valid got=0 exp=1");
      end
      n_checks++; if (got_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rnd_cnt got=%0d exp=%0d", got_cnt, exp_cnt); end
    end
    n_checks++; if (q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drained got=%0d/%b exp=0/0", q.size(), out_valid); end
  endtask

  task automatic test_illegal_sat();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1; immSrc = 3'd7;
    for (int c = 0; c < 300; c++) begin
      instr = $urandom; in_tag = 4'($urandom);
      tick();
      if (popped) begin
        n_checks++;
        if (got_ill !== 1'b1 || got_imm32 !== 32'h0 || got_imm64 !== 64'h0 || got_tag !== exp_item.tag) begin
          n_fail++; $display("FAIL ill_item got=%b/%h/%h/%h exp=1/0/0/%h", got_ill, got_imm32, got_imm64, got_tag, exp_item.tag);
        end
      end
      n_checks++; if (got_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL ill_cnt got=%0d exp=%0d", got_cnt, exp_cnt); end
    end
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (illegal_cnt !== 8'hFF) begin n_fail++; $display("FAIL ill_saturate got=%h exp=ff", illegal_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; immSrc = 3'd0;
    for (int c = 0; c < 2; c++) begin instr = $urandom; in_tag = 4'(c + 5); tick(); end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got=%b/%b exp=1/0", out_valid, in_ready); end
    rst = 1'b1; in_valid = 1'b1; immSrc = 3'd7;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (illegal_cnt !== 8'h0) begin n_fail++; $display("FAIL mid_cnt got=%h exp=0", illegal_cnt); end
    n_checks++; if (immExt !== 32'h0 || out_tag !== 4'h0) begin n_fail++; $display("FAIL mid_data got=%h/%h exp=0/0", immExt, out_tag); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d got=%b exp=0", c, out_valid); end
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready got=%b exp=1", in_ready); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_illegal_sat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
